// File: rtl/rv_instr_encoder.sv
// RV32I field-to-word encoder streaming into an instruction-memory write port.
// Optional immediate range checking is enabled by ENCODER_RANGE_CHECK_EN.
package rv_pkg;
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } rv_op_e;
endpackage

module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  rv_op_e            in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_SYS, F_BAD
    } fmt_e;

    fmt_e        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc;
    logic [31:0] word;
    logic        range_err;
    logic        accept;
    logic        xfer;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_comb begin
        fmt = F_BAD;
        opc = '0;
        f3  = '0;
        f7  = '0;
        unique case (in_op)
            OP_LUI:    begin fmt = F_U;   opc = OPC_LUI; end
            OP_AUIPC:  begin fmt = F_U;   opc = OPC_AUIPC; end
            OP_JAL:    begin fmt = F_J;   opc = OPC_JAL; end
            OP_JALR:   begin fmt = F_I;   opc = OPC_JALR; end
            OP_BEQ:    begin fmt = F_B;   opc = OPC_BR; f3 = 3'b000; end
            OP_BNE:    begin fmt = F_B;   opc = OPC_BR; f3 = 3'b001; end
            OP_BLT:    begin fmt = F_B;   opc = OPC_BR; f3 = 3'b100; end
            OP_BGE:    begin fmt = F_B;   opc = OPC_BR; f3 = 3'b101; end
            OP_BLTU:   begin fmt = F_B;   opc = OPC_BR; f3 = 3'b110; end
            OP_BGEU:   begin fmt = F_B;   opc = OPC_BR; f3 = 3'b111; end
            OP_LB:     begin fmt = F_I;   opc = OPC_LD; f3 = 3'b000; end
            OP_LH:     begin fmt = F_I;   opc = OPC_LD; f3 = 3'b001; end
            OP_LW:     begin fmt = F_I;   opc = OPC_LD; f3 = 3'b010; end
            OP_LBU:    begin fmt = F_I;   opc = OPC_LD; f3 = 3'b100; end
            OP_LHU:    begin fmt = F_I;   opc = OPC_LD; f3 = 3'b101; end
            OP_SB:     begin fmt = F_S;   opc = OPC_ST; f3 = 3'b000; end
            OP_SH:     begin fmt = F_S;   opc = OPC_ST; f3 = 3'b001; end
            OP_SW:     begin fmt = F_S;   opc = OPC_ST; f3 = 3'b010; end
            OP_ADDI:   begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b000; end
            OP_SLTI:   begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b010; end
            OP_SLTIU:  begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b011; end
            OP_XORI:   begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b100; end
            OP_ORI:    begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b110; end
            OP_ANDI:   begin fmt = F_I;   opc = OPC_IMM; f3 = 3'b111; end
            OP_SLLI:   begin fmt = F_SH;  opc = OPC_IMM; f3 = 3'b001; end
            OP_SRLI:   begin fmt = F_SH;  opc = OPC_IMM; f3 = 3'b101; end
            OP_SRAI:   begin fmt = F_SH;  opc = OPC_IMM; f3 = 3'b101; f7 = F7_ALT; end
            OP_ADD:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b000; end
            OP_SUB:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b000; f7 = F7_ALT; end
            OP_SLL:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b001; end
            OP_SLT:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b010; end
            OP_SLTU:   begin fmt = F_R;   opc = OPC_OP; f3 = 3'b011; end
            OP_XOR:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b100; end
            OP_SRL:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b101; end
            OP_SRA:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b101; f7 = F7_ALT; end
            OP_OR:     begin fmt = F_R;   opc = OPC_OP; f3 = 3'b110; end
            OP_AND:    begin fmt = F_R;   opc = OPC_OP; f3 = 3'b111; end
            OP_FENCE:  begin fmt = F_I;   opc = OPC_FENCE; end
            OP_ECALL:  begin fmt = F_SYS; opc = OPC_SYS; end
            OP_EBREAK: begin fmt = F_SYS; opc = OPC_SYS; end
            default:   fmt = F_BAD;
        endcase
    end

    always_comb begin
        enc = NOP;
        unique case (fmt)
            F_R:   enc = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            F_I:   enc = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            F_SH:  enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            F_S:   enc = {in_imm[11:5], in_rs2, in_rs1, f3,
                          in_imm[4:0], opc};
            F_B:   enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                          in_imm[4:1], in_imm[11], opc};
            F_U:   enc = {in_imm[31:12], in_rd, opc};
            F_J:   enc = {in_imm[20], in_imm[10:1], in_imm[11],
                          in_imm[19:12], in_rd, opc};
            F_SYS: enc = {11'd0, in_op == OP_EBREAK, 13'd0, opc};
            default: enc = NOP;
        endcase
    end

    assign word = (fmt == F_BAD || range_err) ? NOP : enc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= word;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // start outranks a same-cycle transfer; a held word is re-addressed, not dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE_ADDR;
            word_cnt <= '0;
        end else if (start) begin
            out_addr <= BASE_ADDR;
            word_cnt <= '0;
        end else if (xfer) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (word_cnt != '1)
                word_cnt <= word_cnt + CNT_W'(1);
        end
    end

`ifdef ENCODER_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        unique case (fmt)
            F_I, F_S: range_err = !(&in_imm[31:11] || !(|in_imm[31:11]));
            F_SH:     range_err = |in_imm[31:5];
            F_B:      range_err = !(&in_imm[31:12] || !(|in_imm[31:12]))
                                  || in_imm[0];
            F_J:      range_err = !(&in_imm[31:20] || !(|in_imm[31:20]))
                                  || in_imm[0];
            F_U:      range_err = |in_imm[11:0];
            F_BAD:    range_err = 1'b1;
            default:  range_err = 1'b0;
        endcase
    end

    // an error accepted alongside start belongs to the freshly started run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (accept && range_err) begin
            err <= 1'b1;
            if (start)
                err_cnt <= CNT_W'(1);
            else if (err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end else if (start) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end
    end
`else
    assign range_err = 1'b0;
    assign err       = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed vector table, corner sequences,
// and a randomized stream checked against a field-packing reference model.
module tb_rv_instr_encoder;
    import rv_pkg::*;

    localparam int          ADDR_W = 8;
    localparam logic [7:0]  BASE   = 8'hFC;
    localparam int          CNT_W  = 4;
    localparam int          CMAX   = 15;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef ENCODER_RANGE_CHECK_EN
    localparam logic [31:0] ADDI2K = 32'h0000_0013;
    localparam bit          RCHK   = 1'b1;
`else
    localparam logic [31:0] ADDI2K = 32'h8000_0093;
    localparam bit          RCHK   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    rv_op_e           in_op = OP_ADDI;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0] word_cnt;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    rv_instr_encoder #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .word_cnt(word_cnt), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_R, M_I, M_SH, M_S, M_B, M_U, M_J, M_SYS, M_BAD} mfmt_e;

    int br_f3[6]  = '{0, 1, 4, 5, 6, 7};
    int ld_f3[5]  = '{0, 1, 2, 4, 5};
    int imm_f3[9] = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    int op_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

    function automatic void info(input rv_op_e op, output mfmt_e f,
                                 output int opc, output int f3,
                                 output int f7);
        int k;
        k = int'(op);
        f = M_BAD; opc = 0; f3 = 0; f7 = 0;
        if (k == int'(OP_LUI)) begin f = M_U; opc = 'h37; end
        else if (k == int'(OP_AUIPC)) begin f = M_U; opc = 'h17; end
        else if (k == int'(OP_JAL)) begin f = M_J; opc = 'h6F; end
        else if (k == int'(OP_JALR)) begin f = M_I; opc = 'h67; end
        else if (k >= int'(OP_BEQ) && k <= int'(OP_BGEU)) begin
            f = M_B; opc = 'h63; f3 = br_f3[k - int'(OP_BEQ)];
        end else if (k >= int'(OP_LB) && k <= int'(OP_LHU)) begin
            f = M_I; opc = 'h03; f3 = ld_f3[k - int'(OP_LB)];
        end else if (k >= int'(OP_SB) && k <= int'(OP_SW)) begin
            f = M_S; opc = 'h23; f3 = k - int'(OP_SB);
        end else if (k >= int'(OP_ADDI) && k <= int'(OP_SRAI)) begin
            f = (k >= int'(OP_SLLI)) ? M_SH : M_I;
            opc = 'h13; f3 = imm_f3[k - int'(OP_ADDI)];
            f7 = (k == int'(OP_SRAI)) ? 32 : 0;
        end else if (k >= int'(OP_ADD) && k <= int'(OP_AND)) begin
            f = M_R; opc = 'h33; f3 = op_f3[k - int'(OP_ADD)];
            f7 = (k == int'(OP_SUB) || k == int'(OP_SRA)) ? 32 : 0;
        end else if (k == int'(OP_FENCE)) begin f = M_I; opc = 'h0F; end
        else if (k == int'(OP_ECALL) || k == int'(OP_EBREAK)) begin
            f = M_SYS; opc = 'h73;
        end
    endfunction

    function automatic bit m_rerr(input rv_op_e op, input logic [31:0] imm);
        mfmt_e f; int opc, f3, f7; longint s;
        info(op, f, opc, f3, f7);
        s = longint'($signed(imm));
        case (f)
            M_I, M_S: return s < -2048 || s > 2047;
            M_SH:     return imm > 31;
            M_B:      return s < -4096 || s > 4095 || imm[0];
            M_J:      return s < -(64'sd1 << 20) || s >= (64'sd1 << 20) || imm[0];
            M_U:      return (imm % 4096) != 0;
            M_BAD:    return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_word(input rv_op_e op,
        input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        mfmt_e f; int opc, f3, f7;
        logic [31:0] base;
        info(op, f, opc, f3, f7);
        if (f == M_BAD) return NOP;
        if (RCHK && m_rerr(op, imm)) return NOP;
        base = (32'(f3) << 12) | 32'(opc);
        case (f)
            M_R:  return base | (32'(f7) << 25) | (32'(rs2) << 20)
                        | (32'(rs1) << 15) | (32'(rd) << 7);
            M_I:  return base | ((imm & 32'hFFF) << 20)
                        | (32'(rs1) << 15) | (32'(rd) << 7);
            M_SH: return base | (32'(f7) << 25) | ((imm & 31) << 20)
                        | (32'(rs1) << 15) | (32'(rd) << 7);
            M_S:  return base | (((imm >> 5) & 127) << 25) | (32'(rs2) << 20)
                        | (32'(rs1) << 15) | ((imm & 31) << 7);
            M_B:  return base | (((imm >> 12) & 1) << 31)
                        | (((imm >> 5) & 63) << 25) | (32'(rs2) << 20)
                        | (32'(rs1) << 15) | (((imm >> 1) & 15) << 8)
                        | (((imm >> 11) & 1) << 7);
            M_U:  return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(opc);
            M_J:  return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                        | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
                        | (32'(rd) << 7) | 32'(opc);
            default: return (op == OP_EBREAK) ? 32'h0010_0073 : 32'h0000_0073;
        endcase
    endfunction

    // ---------------- stream scoreboard ----------------
    logic [31:0] q[$];
    logic [7:0]  e_addr;
    int          e_cnt, e_ecnt;
    bit          e_err;

    always @(negedge clk) begin
        bit xf, ac;
        logic [31:0] w;
        if (!rst_n) begin
            q.delete();
            e_addr = BASE; e_cnt = 0; e_ecnt = 0; e_err = 0;
        end else begin
            xf = out_valid && out_ready;
            ac = in_valid && in_ready;
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (xf) begin
                if (q.size() == 0) begin
                    chk("dup_word", 32'(q.size()), 32'd1);
                end else begin
                    w = q.pop_front();
                    chk("out_instr", out_instr, w);
                    chk("out_addr", 32'(out_addr), 32'(e_addr));
                    chk("word_cnt", 32'(word_cnt), 32'(e_cnt));
                    chk("err", 32'(err), 32'(e_err));
                    chk("err_cnt", 32'(err_cnt), 32'(e_ecnt));
                end
            end
            if (start) begin
                e_addr = BASE; e_cnt = 0; e_ecnt = 0; e_err = 0;
            end else if (xf) begin
                e_addr = e_addr + 8'd4;
                if (e_cnt < CMAX) e_cnt++;
            end
            if (ac) begin
                q.push_back(m_word(in_op, in_rd, in_rs1, in_rs2, in_imm));
                if (RCHK && m_rerr(in_op, in_imm)) begin
                    e_err = 1;
                    if (e_ecnt < CMAX) e_ecnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input rv_op_e op, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] imm);
        bit ok;
        ok = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_instr"}, out_instr, 32'd0);
        chk({tag, "_addr"}, 32'(out_addr), 32'(BASE));
        chk({tag, "_wcnt"}, 32'(word_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
    endtask

    typedef struct {
        string       nm;
        rv_op_e      op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"addi", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093});
        vecs.push_back('{"addi_rs2", OP_ADDI, 5'd1, 5'd0, 5'd31, 32'd5, 32'h0050_0093});
        vecs.push_back('{"lui", OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7});
        vecs.push_back('{"lui_leak", OP_LUI, 5'd5, 5'd7, 5'd9, 32'h1234_5000, 32'h1234_52B7});
        vecs.push_back('{"sub", OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3});
        vecs.push_back('{"beq", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463});
        vecs.push_back('{"jal", OP_JAL, 5'd1, 5'd3, 5'd4, 32'd2048, 32'h0010_00EF});
        vecs.push_back('{"srai", OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093});
        vecs.push_back('{"sw_neg", OP_SW, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 32'hFE51_2E23});
        vecs.push_back('{"ecall", OP_ECALL, 5'd3, 5'd4, 5'd5, 32'd7, 32'h0000_0073});
        vecs.push_back('{"bad_op", rv_op_e'(6'd63), 5'd1, 5'd1, 5'd1, 32'd0, NOP});
        vecs.push_back('{"addi_2048", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, ADDI2K});

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // first word after reset lands at BASE, count steps once it leaves
        out_ready = 1'b1;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("t1_instr", out_instr, 32'h0050_0093);
        chk("t1_addr", 32'(out_addr), 32'(BASE));
        @(posedge clk); #1;
        chk("t1_wcnt", 32'(word_cnt), 32'd1);
        chk("t1_wrap", 32'(out_addr), 32'h00);

        // back-to-back LUI then SUB
        pulse_start();
        chk("t2_start_addr", 32'(out_addr), 32'(BASE));
        chk("t2_start_wcnt", 32'(word_cnt), 32'd0);
        in_op = OP_LUI; in_rd = 5'd5; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_imm = 32'h1234_5000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_op = OP_SUB; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_imm = 32'd0;
        chk("t2_lui", out_instr, 32'h1234_52B7);
        chk("t2_lui_addr", 32'(out_addr), 32'(BASE));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t2_sub", out_instr, 32'h4020_81B3);
        chk("t2_sub_addr", 32'(out_addr), 32'h00);
        @(posedge clk); #1;

        // backpressure: held word and address stay put, input stalls
        out_ready = 1'b0;
        send(OP_ORI, 5'd7, 5'd8, 5'd0, 32'h0000_00FF);
        in_op = OP_XOR; in_rd = 5'd9; in_rs1 = 5'd10; in_rs2 = 5'd11;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_hold_instr", out_instr, 32'h0FF4_6393);
            chk("t4_hold_addr", 32'(out_addr), 32'h04);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_next_instr", out_instr, 32'h00B5_44B3);
        chk("t4_next_addr", 32'(out_addr), 32'h08);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            chk({"vec_", vecs[i].nm}, out_instr, vecs[i].exp);
        end
        @(posedge clk); #1;
        chk("t5_err", 32'(err), 32'(RCHK));
        chk("t5_err_cnt", 32'(err_cnt), RCHK ? 32'd2 : 32'd0);

        // start on the same edge as a transfer wins
        send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd1);
        pulse_start();
        chk("t6_addr", 32'(out_addr), 32'(BASE));
        chk("t6_wcnt", 32'(word_cnt), 32'd0);
        chk("t6_errclr", 32'(err), 32'd0);
        send(OP_ADD, 5'd4, 5'd5, 5'd6, 32'd0);
        chk("t6_first_addr", 32'(out_addr), 32'(BASE));
        send(OP_AND, 5'd4, 5'd5, 5'd6, 32'd0);
        chk("t6_wrap_addr", 32'(out_addr), 32'h00);
        @(posedge clk); #1;

        // start during a stall keeps the word and re-addresses it
        out_ready = 1'b0;
        send(OP_SLTI, 5'd1, 5'd2, 5'd0, 32'd9);
        pulse_start();
        chk("t6_pend_valid", 32'(out_valid), 32'd1);
        chk("t6_pend_addr", 32'(out_addr), 32'(BASE));
        out_ready = 1'b1;
        @(posedge clk); #1;

        // async reset mid-stream drops the pending word
        out_ready = 1'b0;
        send(OP_LW, 5'd3, 5'd4, 5'd0, 32'd16);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized stream
        for (int c = 0; c < 500; c++) begin
            logic [31:0] r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0)
                in_op = rv_op_e'(6'($urandom_range(40, 63)));
            else
                in_op = rv_op_e'(6'($urandom_range(0, 39)));
            in_rd  = 5'($urandom);
            in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: in_imm = r;
                1: in_imm = {{24{r[7]}}, r[7:0]};
                2: in_imm = r & 32'hFFFF_F000;
                default: in_imm = 32'($urandom_range(0, 31)) * 2;
            endcase
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
